// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// --------------
// VGA 640x480@60 raster timing generator. Runs on the 100 MHz system clock
// and emits a one-cycle pixel strobe every CLK_DIV cycles, so all downstream
// logic stays in the single i_clk domain.
//
// Active coordinates are 1-based (x 1..H_ACTIVE, y 1..V_ACTIVE) and read 0
// during blanking, so region compares downstream can use them directly.
//
// Ports:
//   i_clk          system clock
//   i_rst          asynchronous, active-high reset
//   o_pix_stb      one-cycle pixel strobe, every CLK_DIV cycles
//   o_x / o_y      active column / row, 0 in blanking
//   o_active       current pixel is visible
//   o_hsync/vsync  sync outputs, asserted level = SYNC_POL
//   o_line_start   pulses with o_pix_stb at h_cnt == 0
//   o_frame_start  pulses with o_pix_stb at h_cnt == 0, v_cnt == 0
//   o_frame_cnt    (VGA_TIMING_FRAME_CNT_EN only) 16-bit frame counter
//
// Optional build macro: VGA_TIMING_FRAME_CNT_EN adds o_frame_cnt.
//
// All outputs are registered from the counters with one i_clk of latency and
// change only on the edge that raises o_pix_stb; pixel h of line v appears on
// edge (v*H_TOTAL + h)*CLK_DIV + 1 after reset release.

module vga_timing_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_pix_stb,
    output logic [10:0] o_x,
    output logic [9:0]  o_y,
    output logic        o_active,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_line_start,
`ifdef VGA_TIMING_FRAME_CNT_EN
    output logic        o_frame_start,
    output logic [15:0] o_frame_cnt
`else
    output logic        o_frame_start
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    // Counter-width constants keep every compare at native width.
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [10:0]   H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0]   H_S0     = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0]   H_S1     = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [10:0]   H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [9:0]    V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0]    V_S0     = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]    V_S1     = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);
    localparam logic          SYNC_ON  = SYNC_POL[0];

    logic [DW-1:0] div_cnt;
    logic [10:0]   h_cnt;
    logic [9:0]    v_cnt;

    // Combinational view of the pixel addressed by the current counters.
    logic pix_tick;
    logic act_c;
    logic hs_c;
    logic vs_c;
    logic frame_c;

    always_comb begin
        pix_tick = (div_cnt == '0);
        act_c    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        hs_c     = (h_cnt >= H_S0) && (h_cnt <= H_S1);
        vs_c     = (v_cnt >= V_S0) && (v_cnt <= V_S1);
        frame_c  = pix_tick && (h_cnt == '0) && (v_cnt == '0);
    end

    // Divider and raster counters; h/v step at the end of each pixel period,
    // so the next pixel is already addressed when div_cnt returns to 0.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            div_cnt <= '0;
            h_cnt   <= '0;
            v_cnt   <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 11'd1;
            end
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    // Registered outputs. Levels refresh only on the strobe edge so they hold
    // for a full pixel period; pulses are single-cycle with the strobe.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_pix_stb     <= 1'b0;
            o_x           <= '0;
            o_y           <= '0;
            o_active      <= 1'b0;
            o_hsync       <= ~SYNC_ON;
            o_vsync       <= ~SYNC_ON;
            o_line_start  <= 1'b0;
            o_frame_start <= 1'b0;
        end else begin
            o_pix_stb     <= pix_tick;
            o_line_start  <= pix_tick && (h_cnt == '0);
            o_frame_start <= frame_c;
            if (pix_tick) begin
                o_active <= act_c;
                o_x      <= act_c ? h_cnt + 11'd1 : '0;
                o_y      <= act_c ? v_cnt + 10'd1 : '0;
                o_hsync  <= hs_c ? SYNC_ON : ~SYNC_ON;
                o_vsync  <= vs_c ? SYNC_ON : ~SYNC_ON;
            end
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    // The first frame start after reset is frame 0, so it only clears the
    // arm flag; every later frame start increments.
    logic first_frame;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_frame_cnt <= '0;
            first_frame <= 1'b1;
        end else if (frame_c) begin
            if (first_frame) begin
                first_frame <= 1'b0;
            end else begin
                o_frame_cnt <= o_frame_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance (dut) for horizontal timing,
// strobe cadence and reset, plus a shrunken instance (sdut, 16x12 raster,
// CLK_DIV=2, active-high syncs) so whole frames fit in a short run.
module tb_vga_timing_gen;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    always #5 i_clk = ~i_clk;

    logic        d_stb, d_act, d_hs, d_vs, d_ls, d_fs;
    logic [10:0] d_x;
    logic [9:0]  d_y;
    logic        s_stb, s_act, s_hs, s_vs, s_ls, s_fs;
    logic [10:0] s_x;
    logic [9:0]  s_y;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] d_fc, s_fc;
`endif

    vga_timing_gen dut (
        .i_clk(i_clk), .i_rst(i_rst), .o_pix_stb(d_stb), .o_x(d_x), .o_y(d_y),
        .o_active(d_act), .o_hsync(d_hs), .o_vsync(d_vs), .o_line_start(d_ls),
`ifdef VGA_TIMING_FRAME_CNT_EN
        .o_frame_start(d_fs), .o_frame_cnt(d_fc)
`else
        .o_frame_start(d_fs)
`endif
    );

    vga_timing_gen #(
        .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2), .SYNC_POL(1)
    ) sdut (
        .i_clk(i_clk), .i_rst(i_rst), .o_pix_stb(s_stb), .o_x(s_x), .o_y(s_y),
        .o_active(s_act), .o_hsync(s_hs), .o_vsync(s_vs), .o_line_start(s_ls),
`ifdef VGA_TIMING_FRAME_CNT_EN
        .o_frame_start(s_fs), .o_frame_cnt(s_fc)
`else
        .o_frame_start(s_fs)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    int ecnt    = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance to edge e after reset release, then sample 1 time unit later.
    task automatic goto(input int e);
        while (ecnt < e) begin
            @(posedge i_clk);
            ecnt++;
        end
        #1;
    endtask

    initial begin
        int d_bad_stb, d_bad_x, d_bad_y, d_bad_act, d_bad_hs, d_bad_vs, d_bad_ls, d_bad_fs;
        int s_bad_stb, s_bad_x, s_bad_y, s_bad_act, s_bad_hs, s_bad_vs, s_bad_ls, s_bad_fs;
        int s_bad_fc, d_bad_fc, s_bad_per;
        int d_stb_cnt, s_fs_cnt, s_last_fs;
        d_bad_stb = 0; d_bad_x = 0; d_bad_y = 0; d_bad_act = 0;
        d_bad_hs = 0; d_bad_vs = 0; d_bad_ls = 0; d_bad_fs = 0;
        s_bad_stb = 0; s_bad_x = 0; s_bad_y = 0; s_bad_act = 0;
        s_bad_hs = 0; s_bad_vs = 0; s_bad_ls = 0; s_bad_fs = 0;
        s_bad_fc = 0; d_bad_fc = 0; s_bad_per = 0;
        d_stb_cnt = 0; s_fs_cnt = 0; s_last_fs = -1;

        // Reset held for 10 cycles.
        i_rst = 1'b1;
        repeat (10) @(posedge i_clk);
        #1;
        chk("rst_stb",    d_stb, 0);
        chk("rst_x",      d_x,   0);
        chk("rst_y",      d_y,   0);
        chk("rst_active", d_act, 0);
        chk("rst_ls",     d_ls,  0);
        chk("rst_fs",     d_fs,  0);
        chk("rst_hsync",  d_hs,  1);
        chk("rst_vsync",  d_vs,  1);
        chk("rst_s_hsync", s_hs, 0);
        chk("rst_s_vsync", s_vs, 0);

        @(negedge i_clk);
        i_rst = 1'b0;
        ecnt  = 0;

        for (int e = 1; e <= 4000; e++) begin
            int pix, h, l, f;
            logic stb, act, hs, vs;
            goto(e);

            // Full-size reference: 800-pixel lines, CLK_DIV 4, active-low sync.
            stb = ((e - 1) % 4 == 0);
            pix = (e - 1) / 4;
            h   = pix % 800;
            l   = pix / 800;
            act = (h < 640) && (l < 480);
            if (d_stb !== stb) d_bad_stb++;
            if (d_stb === 1'b1) d_stb_cnt++;
            if (d_x !== (act ? 11'(h + 1) : 11'd0)) d_bad_x++;
            if (d_y !== (act ? 10'(l + 1) : 10'd0)) d_bad_y++;
            if (d_act !== act) d_bad_act++;
            if (d_hs !== !((h >= 656) && (h <= 751))) d_bad_hs++;
            if (d_vs !== 1'b1) d_bad_vs++;
            if (d_ls !== (stb && h == 0)) d_bad_ls++;
            if (d_fs !== (stb && h == 0 && l == 0)) d_bad_fs++;
`ifdef VGA_TIMING_FRAME_CNT_EN
            if (d_fc !== 16'd0) d_bad_fc++;
`endif

            // Small reference: 16x12 raster, CLK_DIV 2, active-high sync.
            stb = ((e - 1) % 2 == 0);
            pix = (e - 1) / 2;
            h   = pix % 16;
            l   = (pix / 16) % 12;
            f   = pix / 192;
            act = (h < 8) && (l < 6);
            hs  = (h >= 10) && (h <= 12);
            vs  = (l >= 8) && (l <= 9);
            if (s_stb !== stb) s_bad_stb++;
            if (s_x !== (act ? 11'(h + 1) : 11'd0)) s_bad_x++;
            if (s_y !== (act ? 10'(l + 1) : 10'd0)) s_bad_y++;
            if (s_act !== act) s_bad_act++;
            if (s_hs !== hs) s_bad_hs++;
            if (s_vs !== vs) s_bad_vs++;
            if (s_ls !== (stb && h == 0)) s_bad_ls++;
            if (s_fs !== (stb && h == 0 && l == 0)) s_bad_fs++;
            if (s_fs === 1'b1) begin
                s_fs_cnt++;
                if (s_last_fs >= 0 && (e - s_last_fs) != 384) s_bad_per++;
                s_last_fs = e;
            end
`ifdef VGA_TIMING_FRAME_CNT_EN
            if (s_fc !== 16'(f)) s_bad_fc++;
            if (e == 1)   chk("fc_frame0", s_fc, 0);
            if (e == 385) chk("fc_frame1", s_fc, 1);
            if (e == 769) chk("fc_frame2", s_fc, 2);
`endif

            case (e)
                1: begin
                    chk("e1_stb", d_stb, 1); chk("e1_x", d_x, 1); chk("e1_y", d_y, 1);
                    chk("e1_active", d_act, 1); chk("e1_ls", d_ls, 1); chk("e1_fs", d_fs, 1);
                end
                2:    begin chk("e2_stb", d_stb, 0); chk("e2_x_hold", d_x, 1); chk("e2_fs", d_fs, 0); end
                5:    chk("e5_x", d_x, 2);
                2557: chk("h639_x", d_x, 640);
                2561: begin chk("h640_x", d_x, 0); chk("h640_active", d_act, 0); end
                2621: chk("h655_hsync", d_hs, 1);
                2625: chk("h656_hsync", d_hs, 0);
                3008: chk("h751_hsync", d_hs, 0);
                3009: chk("h752_hsync", d_hs, 1);
                3201: begin chk("l1_y", d_y, 2); chk("l1_ls", d_ls, 1); chk("l1_fs", d_fs, 0); end
                default: ;
            endcase
        end

        chk("d_stb_count", d_stb_cnt, 1000);
        chk("d_bad_stb", d_bad_stb, 0);
        chk("d_bad_x",   d_bad_x,   0);
        chk("d_bad_y",   d_bad_y,   0);
        chk("d_bad_act", d_bad_act, 0);
        chk("d_bad_hs",  d_bad_hs,  0);
        chk("d_bad_vs",  d_bad_vs,  0);
        chk("d_bad_ls",  d_bad_ls,  0);
        chk("d_bad_fs",  d_bad_fs,  0);
        chk("s_bad_stb", s_bad_stb, 0);
        chk("s_bad_x",   s_bad_x,   0);
        chk("s_bad_y",   s_bad_y,   0);
        chk("s_bad_act", s_bad_act, 0);
        chk("s_bad_hs",  s_bad_hs,  0);
        chk("s_bad_vs",  s_bad_vs,  0);
        chk("s_bad_ls",  s_bad_ls,  0);
        chk("s_bad_fs",  s_bad_fs,  0);
        chk("s_fs_count", s_fs_cnt, 11);
        chk("s_fs_period", s_bad_per, 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
        chk("s_bad_fc", s_bad_fc, 0);
        chk("d_bad_fc", d_bad_fc, 0);
`endif

        // Mid-line reset: line 1, pixel 300 of the full-size raster.
        goto(4403);
        chk("pre_rst_x", d_x, 301);
        i_rst = 1'b1;
        #1;
        chk("async_x",      d_x,   0);
        chk("async_y",      d_y,   0);
        chk("async_active", d_act, 0);
        chk("async_hsync",  d_hs,  1);
        chk("async_s_x",    s_x,   0);
        chk("async_s_vsync", s_vs, 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
        chk("async_fc", s_fc, 0);
`endif
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        ecnt  = 0;
        goto(1);
        chk("rerst_stb", d_stb, 1);
        chk("rerst_x",   d_x,   1);
        chk("rerst_y",   d_y,   1);
        chk("rerst_fs",  d_fs,  1);
        chk("rerst_s_fs", s_fs, 1);
`ifdef VGA_TIMING_FRAME_CNT_EN
        chk("rerst_fc", s_fc, 0);
`endif
        goto(5);
        chk("rerst_e5_x", d_x, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
